brch_resolve_unit: RTL and testbench

Parametrised, pipelined successor to the combinational branch-condition logic. Registers the ALU flags with the branch control code and evaluates set-compare results (SEQ/SLT/SLE/SCO/SNE/SLTU) and branch/jump conditions. Compares the actual outcome against the fetch-stage prediction and issues a PC redirect to fetch over a valid/ready handshake. Sits at the EX/MEM boundary; also keeps saturating branch and mispredict counters.

---
 rtl/brch_pkg.sv | 34 +++
 rtl/brch_sat_counter.sv | 15 +
 rtl/brch_resolve_unit.sv | 88 ++++++++
 tb/tb_brch_resolve_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/brch_pkg.sv
// brch_pkg: opcode/state types and condition evaluation for the branch resolve unit
package brch_pkg;
    typedef enum logic [3:0] {
        OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_BEQZ, OP_BNEZ,
        OP_BLTZ, OP_BGEZ, OP_JMP, OP_SNE, OP_SLTU
    } brch_op_e;
    typedef enum logic {IDLE, HOLD} state_e;
    typedef struct packed {
        logic is_cmp;
        logic is_br;
        logic res;
    } cond_t;
    function automatic cond_t eval_cond(input logic [3:0] op, input logic sf, zf, of, cf);
        logic lt;
        cond_t c;
        lt = sf ^ of;
        c = '0;
        case (op)
            OP_SEQ:  c = {1'b1, 1'b0, zf};
            OP_SLT:  c = {1'b1, 1'b0, lt};
            OP_SLE:  c = {1'b1, 1'b0, lt | zf};
            OP_SCO:  c = {1'b1, 1'b0, cf};
            OP_SNE:  c = {1'b1, 1'b0, ~zf};
            OP_SLTU: c = {1'b1, 1'b0, ~cf};
            OP_BEQZ: c = {1'b0, 1'b1, zf};
            OP_BNEZ: c = {1'b0, 1'b1, ~zf};
            OP_BLTZ: c = {1'b0, 1'b1, lt};
            OP_BGEZ: c = {1'b0, 1'b1, ~lt};
            OP_JMP:  c = {1'b0, 1'b1, 1'b1};
            default: c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/brch_sat_counter.sv
// brch_sat_counter: event counter that sticks at all-ones
module brch_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    // count up on inc, never wrap past all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= (inc && cnt != '1) ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/brch_resolve_unit.sv
// brch_resolve_unit: pipelined compare/branch resolution with redirect handshake and stats
module brch_resolve_unit
    import brch_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        brch_ctrl,
    input  logic              sf,
    input  logic              zf,
    input  logic              of,
    input  logic              cf,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] tgt_pc,
    input  logic [ADDR_W-1:0] seq_pc,
    input  logic              flush,
    output logic              cmp_valid,
    output logic [DATA_W-1:0] cmp_result,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    input  logic              redir_ready,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);
    logic              s1_valid, s1_sf, s1_zf, s1_of, s1_cf, s1_pred, last_bit;
    logic [3:0]        s1_op;
    logic [ADDR_W-1:0] s1_tgt, s1_seq, hold_pc, fix_pc;
    state_e            state;
    cond_t             c;
    logic              live, mispred;

    assign c           = eval_cond(s1_op, s1_sf, s1_zf, s1_of, s1_cf);
    assign live        = s1_valid & ~flush;
    assign mispred     = live & c.is_br & (c.res != s1_pred);
    assign fix_pc      = c.res ? s1_tgt : s1_seq;
    assign redir_valid = (state == HOLD) | mispred;
    assign redir_pc    = mispred ? fix_pc : hold_pc;
    assign in_ready    = ~redir_valid;
    assign cmp_valid   = live & c.is_cmp;
    assign cmp_result  = {{(DATA_W-1){1'b0}}, cmp_valid ? c.res : last_bit};

    // stage 1: capture the accepted op; flush kills anything arriving with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            {s1_sf, s1_zf, s1_of, s1_cf, s1_pred} <= '0;
            s1_tgt   <= '0;
            s1_seq   <= '0;
        end else begin
            s1_valid <= in_valid & in_ready & ~flush;
            if (in_valid & in_ready) begin
                s1_op    <= brch_ctrl;
                {s1_sf, s1_zf, s1_of, s1_cf, s1_pred} <= {sf, zf, of, cf, pred_taken};
                s1_tgt   <= tgt_pc;
                s1_seq   <= seq_pc;
            end
        end
    end

    // redirect FSM: a mispredict not accepted immediately is held until fetch takes it or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_pc  <= '0;
            last_bit <= 1'b0;
        end else begin
            if (mispred) hold_pc <= fix_pc;
            if (cmp_valid) last_bit <= c.res;
            state <= flush ? IDLE :
                     (state == HOLD) ? (redir_ready ? IDLE : HOLD) :
                     (mispred && !redir_ready) ? HOLD : IDLE;
        end
    end

    brch_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk(clk), .rst_n(rst_n), .inc(live & c.is_br), .cnt(br_cnt)
    );

    brch_sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk(clk), .rst_n(rst_n), .inc(mispred), .cnt(mispred_cnt)
    );
endmodule

// File: tb/tb_brch_resolve_unit.sv
// tb_brch_resolve_unit: directed and randomized checks of brch_resolve_unit against a reference model
module tb_brch_resolve_unit;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 0, rst_n = 0, in_valid = 0, in_ready, sf = 0, zf = 0, of = 0, cf = 0;
    logic pred_taken = 0, flush = 0, cmp_valid, redir_valid, redir_ready = 0;
    logic [3:0] brch_ctrl = 0;
    logic [ADDR_W-1:0] tgt_pc = 0, seq_pc = 0, redir_pc;
    logic [DATA_W-1:0] cmp_result;
    logic [CNT_W-1:0] br_cnt, mispred_cnt;
    int ntests = 0, nfail = 0;

    brch_resolve_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .brch_ctrl(brch_ctrl), .sf(sf), .zf(zf), .of(of), .cf(cf),
        .pred_taken(pred_taken), .tgt_pc(tgt_pc), .seq_pc(seq_pc), .flush(flush),
        .cmp_valid(cmp_valid), .cmp_result(cmp_result), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .redir_ready(redir_ready), .br_cnt(br_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // reference semantics: kind 0 = nothing, 1 = compare, 2 = branch/jump
    function automatic void model_cond(input int op, input bit s, z, o, c, output int kind, output bit r);
        bit less = (s != o);
        kind = (op <= 3 || op == 9 || op == 10) ? 1 : (op >= 4 && op <= 8) ? 2 : 0;
        case (op)
            0: r = z;
            1: r = less;
            2: r = less || z;
            3: r = c;
            4: r = z;
            5: r = !z;
            6: r = less;
            7: r = !less;
            8: r = 1;
            9: r = !z;
            10: r = !c;
            default: r = 0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 0; in_valid = 0; flush = 0; redir_ready = 0;
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic issue(input [3:0] op, input [3:0] f, input p, input [15:0] t, input [15:0] s);
        in_valid = 1; brch_ctrl = op; {sf, zf, of, cf} = f; pred_taken = p; tgt_pc = t; seq_pc = s;
        @(posedge clk); #1 in_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        ntests++; if (redir_valid !== 1'b0) begin nfail++; $display("FAIL reset_redir_valid got %b exp 0", redir_valid); end
        ntests++; if (cmp_valid !== 1'b0) begin nfail++; $display("FAIL reset_cmp_valid got %b exp 0", cmp_valid); end
        ntests++; if (cmp_result !== 16'h0) begin nfail++; $display("FAIL reset_cmp_result got %h exp 0", cmp_result); end
        ntests++; if (redir_pc !== 16'h0) begin nfail++; $display("FAIL reset_redir_pc got %h exp 0", redir_pc); end
        ntests++; if ({br_cnt, mispred_cnt} !== 4'h0) begin nfail++; $display("FAIL reset_counters got %h/%h exp 0/0", br_cnt, mispred_cnt); end
    endtask

    task automatic test_compare();
        issue(4'd0, 4'b0100, 0, 0, 0);
        ntests++; if (cmp_valid !== 1'b1) begin nfail++; $display("FAIL seq_cmp_valid got %b exp 1", cmp_valid); end
        ntests++; if (cmp_result !== 16'h0001) begin nfail++; $display("FAIL seq_cmp_result got %h exp 0001", cmp_result); end
        @(posedge clk); #1;
        ntests++; if (cmp_valid !== 1'b0) begin nfail++; $display("FAIL seq_cmp_valid_drop got %b exp 0", cmp_valid); end
        ntests++; if (cmp_result !== 16'h0001) begin nfail++; $display("FAIL seq_cmp_hold got %h exp 0001", cmp_result); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; brch_ctrl = 4'd1; {sf, zf, of, cf} = 4'b1000;
        @(posedge clk); #1;
        brch_ctrl = 4'd10; {sf, zf, of, cf} = 4'b0001;
        ntests++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
        ntests++; if (cmp_valid !== 1'b1 || cmp_result !== 16'h0001) begin nfail++; $display("FAIL b2b_slt got %b/%h exp 1/0001", cmp_valid, cmp_result); end
        @(posedge clk); #1 in_valid = 0;
        ntests++; if (cmp_valid !== 1'b1 || cmp_result !== 16'h0000) begin nfail++; $display("FAIL b2b_sltu got %b/%h exp 1/0000", cmp_valid, cmp_result); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        issue(4'd4, 4'b0100, 0, 16'h0040, 16'h0044);
        for (int i = 0; i < 3; i++) begin
            ntests++; if (redir_valid !== 1'b1 || redir_pc !== 16'h0040 || in_ready !== 1'b0) begin nfail++; $display("FAIL hold_cycle%0d got v=%b pc=%h rdy=%b exp 1/0040/0", i, redir_valid, redir_pc, in_ready); end
            @(posedge clk); #1;
        end
        redir_ready = 1;
        @(posedge clk); #1 redir_ready = 0;
        ntests++; if (redir_valid !== 1'b0 || in_ready !== 1'b1) begin nfail++; $display("FAIL hold_release got v=%b rdy=%b exp 0/1", redir_valid, in_ready); end
        ntests++; if (br_cnt !== 2'd1 || mispred_cnt !== 2'd1) begin nfail++; $display("FAIL hold_counters got %0d/%0d exp 1/1", br_cnt, mispred_cnt); end
    endtask

    task automatic test_bnez_jmp();
        do_reset();
        redir_ready = 1;
        issue(4'd5, 4'b0100, 1, 16'h0050, 16'h0022);
        ntests++; if (redir_valid !== 1'b1 || redir_pc !== 16'h0022) begin nfail++; $display("FAIL bnez_redir got v=%b pc=%h exp 1/0022", redir_valid, redir_pc); end
        @(posedge clk); #1;
        issue(4'd8, 4'b0000, 1, 16'h0060, 16'h0024);
        ntests++; if (redir_valid !== 1'b0) begin nfail++; $display("FAIL jmp_no_redir got %b exp 0", redir_valid); end
        @(posedge clk); #1 redir_ready = 0;
        ntests++; if (br_cnt !== 2'd2 || mispred_cnt !== 2'd1) begin nfail++; $display("FAIL jmp_counters got %0d/%0d exp 2/1", br_cnt, mispred_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(4'd6, 4'b1000, 0, 16'h0080, 16'h0084);
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        ntests++; if (redir_valid !== 1'b0 || in_ready !== 1'b1) begin nfail++; $display("FAIL flush_hold got v=%b rdy=%b exp 0/1", redir_valid, in_ready); end
        ntests++; if (br_cnt !== 2'd1 || mispred_cnt !== 2'd1) begin nfail++; $display("FAIL flush_counters got %0d/%0d exp 1/1", br_cnt, mispred_cnt); end
        issue(4'd4, 4'b0100, 0, 16'h0090, 16'h0094);
        flush = 1; #1;
        ntests++; if (redir_valid !== 1'b0 || cmp_valid !== 1'b0) begin nfail++; $display("FAIL flush_s1 got v=%b cv=%b exp 0/0", redir_valid, cmp_valid); end
        @(posedge clk); #1 flush = 0;
        ntests++; if (br_cnt !== 2'd1 || mispred_cnt !== 2'd1 || redir_valid !== 1'b0) begin nfail++; $display("FAIL flush_s1_after got %0d/%0d v=%b exp 1/1/0", br_cnt, mispred_cnt, redir_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        redir_ready = 1;
        for (int i = 0; i < 5; i++) begin
            issue(4'd7, 4'b0000, 0, 16'h0100 + 16'(i), 16'h0200);
            @(posedge clk); #1;
        end
        redir_ready = 0;
        ntests++; if (mispred_cnt !== 2'd3 || br_cnt !== 2'd3) begin nfail++; $display("FAIL saturate got %0d/%0d exp 3/3", br_cnt, mispred_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(4'd0, 4'b0100, 0, 0, 0);
        issue(4'd4, 4'b0100, 0, 16'h0040, 16'h0044);
        @(posedge clk); #1;
        ntests++; if (redir_valid !== 1'b1 || cmp_result !== 16'h0001) begin nfail++; $display("FAIL arst_pre got v=%b res=%h exp 1/0001", redir_valid, cmp_result); end
        #2 rst_n = 0;
        #1;
        ntests++; if (redir_valid !== 1'b0 || redir_pc !== 16'h0 || in_ready !== 1'b1) begin nfail++; $display("FAIL arst_redir got v=%b pc=%h rdy=%b exp 0/0000/1", redir_valid, redir_pc, in_ready); end
        ntests++; if (cmp_result !== 16'h0 || br_cnt !== 2'd0 || mispred_cnt !== 2'd0) begin nfail++; $display("FAIL arst_state got res=%h %0d/%0d exp 0/0/0", cmp_result, br_cnt, mispred_cnt); end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_random();
        int m_br, m_mp, kind;
        bit m_v, m_hold, m_last, m_pred, m_sf, m_zf, m_of, m_cf, b, live, misp, e_rv, e_cv;
        int m_op;
        logic [15:0] m_tgt, m_seq, m_hpc, e_pc;
        do_reset();
        {m_br, m_mp, m_op} = '0;
        {m_v, m_hold, m_last, m_pred, m_sf, m_zf, m_of, m_cf} = '0;
        {m_tgt, m_seq, m_hpc} = '0;
        for (int n = 0; n < 500; n++) begin
            in_valid = 1'($urandom_range(0, 1)); brch_ctrl = 4'($urandom_range(0, 15));
            {sf, zf, of, cf} = 4'($urandom_range(0, 15)); pred_taken = 1'($urandom_range(0, 1));
            tgt_pc = 16'($urandom); seq_pc = 16'($urandom);
            redir_ready = 1'($urandom_range(0, 1)); flush = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            model_cond(m_op, m_sf, m_zf, m_of, m_cf, kind, b);
            live = m_v && !flush;
            misp = live && kind == 2 && b != m_pred;
            e_rv = m_hold || misp;
            e_pc = misp ? (b ? m_tgt : m_seq) : m_hpc;
            e_cv = live && kind == 1;
            ntests++; if (redir_valid !== e_rv || in_ready !== !e_rv) begin nfail++; $display("FAIL rnd%0d_redir_valid got v=%b rdy=%b exp v=%b", n, redir_valid, in_ready, e_rv); end
            if (e_rv) begin
                ntests++; if (redir_pc !== e_pc) begin nfail++; $display("FAIL rnd%0d_redir_pc got %h exp %h", n, redir_pc, e_pc); end
            end
            ntests++; if (cmp_valid !== e_cv || cmp_result !== {15'h0, e_cv ? b : m_last}) begin nfail++; $display("FAIL rnd%0d_cmp got %b/%h exp %b/%0d", n, cmp_valid, cmp_result, e_cv, e_cv ? b : m_last); end
            ntests++; if (br_cnt !== CNT_W'(m_br) || mispred_cnt !== CNT_W'(m_mp)) begin nfail++; $display("FAIL rnd%0d_cnt got %0d/%0d exp %0d/%0d", n, br_cnt, mispred_cnt, m_br, m_mp); end
            if (live && kind == 2) m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
            if (misp) begin m_mp = (m_mp < CMAX) ? m_mp + 1 : CMAX; m_hpc = e_pc; end
            if (e_cv) m_last = b;
            m_hold = flush ? 0 : m_hold ? !redir_ready : (misp && !redir_ready);
            m_v = in_valid && !e_rv && !flush;
            if (in_valid && !e_rv) begin
                m_op = int'(brch_ctrl); {m_sf, m_zf, m_of, m_cf} = {sf, zf, of, cf};
                m_pred = pred_taken; m_tgt = tgt_pc; m_seq = seq_pc;
            end
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 0; redir_ready = 0;
    endtask

    initial begin
        test_reset();
        test_compare();
        test_back_to_back();
        test_redirect_hold();
        test_bnez_jmp();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
